mwpipe_v: RTL and testbench
===========================

MWPIPE_V -- requirements
Module: mwpipe_v

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning vector lane count (1..8).
REQ-002 The block SHALL have parameter LANE_W, default 32, meaning bits per lane.
REQ-003 The block SHALL have parameter REG_AW, default 4, meaning register index width.
REQ-004 The block SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port flush_W  in  1  discard all held entries.
REQ-007 The block SHALL have port valid_M  in  1  M-stage entry present.
REQ-008 The block SHALL have port ready_M  out  1  block can accept an entry.
REQ-009 The block SHALL have ports regw_M and regmem_M  in  1 each  register write and memory-result select.
REQ-010 The block SHALL have port regScr_M  in  REG_AW  destination register.
REQ-011 The block SHALL have port lanemask_M  in  LANES  per-lane write enable.
REQ-012 The block SHALL have ports ALUrslt_M and readdata_M  in  LANES*LANE_W each  ALU result and memory read data.
REQ-013 The block SHALL have port valid_W  out  1  W-stage entry present.
REQ-014 The block SHALL have port ready_W  in  1  writeback can consume; low equals stall.
REQ-015 The block SHALL have ports regw_W, regScr_W and lanemask_W  out  1 / REG_AW / LANES  registered control.
REQ-016 The block SHALL have port wbdata_W  out  LANES*LANE_W  selected writeback data.

Function
REQ-017 The block SHALL transfer on the M side when valid_M&&ready_M at a rising edge, and on the W side when valid_W&&ready_W.
REQ-018 The block SHALL hold a main register and one skid register, giving at most 2 entries.
REQ-019 The block SHALL present an entry accepted into an empty main register on the W outputs the next cycle, for a latency of 1.
REQ-020 When the main register is full and its entry is not consumed, the block SHALL place a new accepted entry in the skid register.
REQ-021 The block SHALL register ready_M and drive it as !skid_valid, so no combinational path runs from ready_W to ready_M.
REQ-022 When the main entry is consumed and the skid register is valid, the block SHALL move the skid entry to main the same edge, and SHALL accept any simultaneous new entry into skid only if ready_M was high.
REQ-023 The block SHALL keep entry order strictly FIFO, with no drops and no duplicates.
REQ-024 The block SHALL set wbdata_W lane i to readdata lane i when regmem is 1, else to ALUrslt lane i, with the choice fixed at acceptance.
REQ-025 When valid_W=0, the block SHALL drive regw_W=0 and lanemask_W=0, with wbdata_W don't-care.
REQ-026 The block SHALL force regw to 0 on acceptance when lanemask_M is all zeros.
REQ-027 On flush_W at an edge, the block SHALL clear both valid bits, drop any simultaneous M-side entry, and set ready_M=1 next cycle; flush SHALL take priority over accept and consume.
REQ-028 While valid_W=1 and ready_W=0, the block SHALL keep all W outputs stable.

Reset
REQ-029 On an edge with rst=0, the block SHALL clear both valid bits, regw_W, lanemask_W and regScr_W, and zero the data registers.
REQ-030 The block SHALL hold ready_M=0 while rst=0 and drive it 1 on the first edge after rst returns to 1.
REQ-031 A reset that arrives mid-stall SHALL discard held entries without emitting them.

Configuration
REQ-032 With macro MWPIPE_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_reg (REG_AW) and fwd_data (LANES*LANE_W), driven as valid_W&&regw_W, regScr_W and wbdata_W, for the hazard unit.
REQ-033 Without MWPIPE_FWD_EN, the block SHALL have none of these ports and no added logic.

Structure
REQ-034 Package vp_pkg SHALL hold the lane_t typedef (LANE_W bits), the regidx_t typedef, and a packed mw_entry_t struct of {regw, regmem, regScr, lanemask, data}.
REQ-035 Sub-module mwpipe_skid, a generic 2-entry valid/ready skid buffer parametrised on payload width, SHALL hold the storage; mwpipe_v SHALL do lane selection, masking and forwarding.

Verification
REQ-036 Reset-release test: hold rst=0 for 3 cycles, then release -> valid_W=0, regw_W=0, ready_M=1 one cycle after release.
REQ-037 Single-entry test: send valid_M=1, regw=1, regmem=0, regScr=3, mask=4'hF, ALUrslt=128'h0000FFFF with ready_W=1 -> next cycle valid_W=1, regScr_W=3, wbdata_W=128'h0000FFFF.
REQ-038 Stall test: ready_W=0, then entries A (regScr=3) and B (regScr=4) -> ready_M=0 after B; release the stall -> A, then B on consecutive cycles, and ready_M=1.
REQ-039 Memory-select test: regmem=1, readdata=128'hDEAD_BEEF, ALUrslt=0 -> wbdata_W=128'hDEAD_BEEF.
REQ-040 Flush test: 2 entries held under stall, then flush_W=1 while valid_M=1 -> next cycle valid_W=0, ready_M=1, the M entry is lost, and nothing later emerges.
REQ-041 Zero-mask test: lanemask_M=0 with regw_M=1 -> regw_W=0 with valid_W=1; with MWPIPE_FWD_EN defined, fwd_valid=0.

Source files
------------

// File: rtl/mwpipe_v_pkg.sv
// Shared types and default geometry for the M->W writeback pipeline register.
package vp_pkg;
  localparam int VP_LANES  = 4;
  localparam int VP_LANE_W = 32;
  localparam int VP_REG_AW = 4;

  typedef logic [VP_LANE_W-1:0] lane_t;
  typedef logic [VP_REG_AW-1:0] regidx_t;

  typedef struct packed {
    logic                           regw;
    logic                           regmem;
    regidx_t                        regScr;
    logic [VP_LANES-1:0]            lanemask;
    logic [VP_LANES*VP_LANE_W-1:0]  data;
  } mw_entry_t;
endpackage

// File: rtl/mwpipe_v_if.sv
// M-side and W-side handshake bundle; slave is the pipeline view, master drives it.
interface mwpipe_v_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int REG_AW = 4
);
  logic                     flush_W;
  logic                     valid_M;
  logic                     ready_M;
  logic                     regw_M;
  logic                     regmem_M;
  logic [REG_AW-1:0]        regScr_M;
  logic [LANES-1:0]         lanemask_M;
  logic [LANES*LANE_W-1:0]  ALUrslt_M;
  logic [LANES*LANE_W-1:0]  readdata_M;
  logic                     valid_W;
  logic                     ready_W;
  logic                     regw_W;
  logic [REG_AW-1:0]        regScr_W;
  logic [LANES-1:0]         lanemask_W;
  logic [LANES*LANE_W-1:0]  wbdata_W;

  modport slave (
    input  flush_W, valid_M, regw_M, regmem_M, regScr_M, lanemask_M,
           ALUrslt_M, readdata_M, ready_W,
    output ready_M, valid_W, regw_W, regScr_W, lanemask_W, wbdata_W
  );

  modport master (
    output flush_W, valid_M, regw_M, regmem_M, regScr_M, lanemask_M,
           ALUrslt_M, readdata_M, ready_W,
    input  ready_M, valid_W, regw_W, regScr_W, lanemask_W, wbdata_W
  );
endinterface

// File: rtl/mwpipe_skid.sv
// Generic 2-entry valid/ready skid buffer: main register feeds the output,
// skid register absorbs one extra entry so ready_o can be fully registered.
module mwpipe_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         ready_q, ready_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc_s, cons_s;

  // Next-state: flush wins, then fill main, refill from skid, or park in skid.
  always_comb begin
    acc_s    = valid_i && ready_q;
    cons_s   = main_v_q && ready_i;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      main_v_d = acc_s;
      if (acc_s) begin
        main_d = data_i;
      end else begin
        main_d = main_q;
      end
    end else if (cons_s) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = acc_s;
        if (acc_s) begin
          skid_d = data_i;
        end else begin
          skid_d = skid_q;
        end
      end else begin
        main_v_d = acc_s;
        if (acc_s) begin
          main_d = data_i;
        end else begin
          main_d = main_q;
        end
      end
    end else if (acc_s) begin
      skid_v_d = 1'b1;
      skid_d   = data_i;
    end else begin
      skid_v_d = skid_v_q;
    end
    ready_d = !skid_v_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = main_v_q;
  assign data_o  = main_q;
endmodule

// File: rtl/mwpipe_v.sv
// M->W pipeline register with per-lane writeback select and zero-mask regw suppression.
// Optional hazard-unit forwarding outputs are enabled by macro MWPIPE_FWD_EN.
module mwpipe_v
  import vp_pkg::*;
#(
  parameter int LANES  = VP_LANES,
  parameter int LANE_W = VP_LANE_W,
  parameter int REG_AW = VP_REG_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  mwpipe_v_if.slave               bus
`ifdef MWPIPE_FWD_EN
  ,
  output logic                    fwd_valid,
  output logic [REG_AW-1:0]       fwd_reg,
  output logic [LANES*LANE_W-1:0] fwd_data
`endif
);
  localparam int DW = LANES * LANE_W;
  localparam int PW = 1 + REG_AW + LANES + DW;

  logic [DW-1:0] wdata_m_s;
  logic          regw_m_s;
  logic [PW-1:0] pay_m_s;
  logic [PW-1:0] pay_w_s;
  logic          valid_w_s;

  // The memory/ALU choice is made here so the stored entry carries final data.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wdata_m_s[i*LANE_W +: LANE_W] = bus.regmem_M ? bus.readdata_M[i*LANE_W +: LANE_W]
                                                   : bus.ALUrslt_M[i*LANE_W +: LANE_W];
    end
    regw_m_s = bus.regw_M & (|bus.lanemask_M);
  end

  assign pay_m_s = {regw_m_s, bus.regScr_M, bus.lanemask_M, wdata_m_s};

  mwpipe_skid #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush_W),
    .valid_i (bus.valid_M),
    .ready_o (bus.ready_M),
    .data_i  (pay_m_s),
    .valid_o (valid_w_s),
    .ready_i (bus.ready_W),
    .data_o  (pay_w_s)
  );

  assign bus.valid_W    = valid_w_s;
  assign bus.regw_W     = valid_w_s & pay_w_s[PW-1];
  assign bus.regScr_W   = pay_w_s[PW-2 -: REG_AW];
  assign bus.lanemask_W = pay_w_s[DW +: LANES] & {LANES{valid_w_s}};
  assign bus.wbdata_W   = pay_w_s[DW-1:0];

`ifdef MWPIPE_FWD_EN
  assign fwd_valid = valid_w_s & pay_w_s[PW-1];
  assign fwd_reg   = pay_w_s[PW-2 -: REG_AW];
  assign fwd_data  = pay_w_s[DW-1:0];
`endif
endmodule

// File: tb/tb_mwpipe_v.sv
// Directed self-checking bench for mwpipe_v with hand-computed expectations.
module tb_mwpipe_v;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int REG_AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mwpipe_v_if #(.LANES(LANES), .LANE_W(LANE_W), .REG_AW(REG_AW)) bus ();

`ifdef MWPIPE_FWD_EN
  logic                    fwd_valid;
  logic [REG_AW-1:0]       fwd_reg;
  logic [LANES*LANE_W-1:0] fwd_data;
`endif

  mwpipe_v #(.LANES(LANES), .LANE_W(LANE_W), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef MWPIPE_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data)
`endif
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic regw, input logic regmem,
                         input logic [3:0] scr, input logic [3:0] mask,
                         input logic [127:0] alu, input logic [127:0] rd);
    bus.valid_M    = v;
    bus.regw_M     = regw;
    bus.regmem_M   = regmem;
    bus.regScr_M   = scr;
    bus.lanemask_M = mask;
    bus.ALUrslt_M  = alu;
    bus.readdata_M = rd;
  endtask

  task automatic idle_m();
    drive_m(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 128'd0, 128'd0);
  endtask

  initial begin
    rst         = 1'b0;
    bus.flush_W = 1'b0;
    bus.ready_W = 1'b1;
    idle_m();

    // Reset release
    repeat (3) tick();
    check("rst_ready_low", 128'(bus.ready_M), 128'd0);
    check("rst_valid_low", 128'(bus.valid_W), 128'd0);
    rst = 1'b1;
    tick();
    check("rel_ready", 128'(bus.ready_M), 128'd1);
    check("rel_valid", 128'(bus.valid_W), 128'd0);
    check("rel_regw", 128'(bus.regw_W), 128'd0);
    check("rel_mask", 128'(bus.lanemask_W), 128'd0);
    check("rel_scr", 128'(bus.regScr_W), 128'd0);

    // Single entry, latency 1
    drive_m(1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 128'h0000FFFF, 128'h12345678);
    tick();
    idle_m();
    check("single_valid", 128'(bus.valid_W), 128'd1);
    check("single_scr", 128'(bus.regScr_W), 128'd3);
    check("single_data", bus.wbdata_W, 128'h0000FFFF);
    check("single_regw", 128'(bus.regw_W), 128'd1);
    check("single_mask", 128'(bus.lanemask_W), 128'(4'hF));
    tick();
    check("single_drain", 128'(bus.valid_W), 128'd0);
    check("single_mask0", 128'(bus.lanemask_W), 128'd0);

    // Stall: A to main, B to skid, ready_M drops
    bus.ready_W = 1'b0;
    drive_m(1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 128'hAAAA, 128'd0);
    tick();
    check("stall_a_ready", 128'(bus.ready_M), 128'd1);
    check("stall_a_scr", 128'(bus.regScr_W), 128'd3);
    drive_m(1'b1, 1'b1, 1'b0, 4'd4, 4'hF, 128'hBBBB, 128'd0);
    tick();
    idle_m();
    check("stall_b_ready", 128'(bus.ready_M), 128'd0);
    check("stall_b_front", 128'(bus.regScr_W), 128'd3);
    tick();
    check("stall_hold_scr", 128'(bus.regScr_W), 128'd3);
    check("stall_hold_data", bus.wbdata_W, 128'hAAAA);
    check("stall_hold_valid", 128'(bus.valid_W), 128'd1);
    // Release with C offered while ready_M=0: C must not enter this edge
    bus.ready_W = 1'b1;
    drive_m(1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 128'hCCCC, 128'd0);
    tick();
    check("rel_b_scr", 128'(bus.regScr_W), 128'd4);
    check("rel_b_data", bus.wbdata_W, 128'hBBBB);
    check("rel_b_ready", 128'(bus.ready_M), 128'd1);
    tick();
    idle_m();
    check("rel_c_scr", 128'(bus.regScr_W), 128'd5);
    check("rel_c_data", bus.wbdata_W, 128'hCCCC);
    tick();
    check("rel_empty", 128'(bus.valid_W), 128'd0);

    // Memory select
    drive_m(1'b1, 1'b1, 1'b1, 4'd7, 4'hF, 128'd0, 128'hDEAD_BEEF);
    tick();
    idle_m();
    check("mem_data", bus.wbdata_W, 128'hDEAD_BEEF);
    check("mem_scr", 128'(bus.regScr_W), 128'd7);
    tick();

    // Flush with two held entries and a simultaneous M entry
    bus.ready_W = 1'b0;
    drive_m(1'b1, 1'b1, 1'b0, 4'd1, 4'hF, 128'h1111, 128'd0);
    tick();
    drive_m(1'b1, 1'b1, 1'b0, 4'd2, 4'hF, 128'h2222, 128'd0);
    tick();
    check("flush_pre_ready", 128'(bus.ready_M), 128'd0);
    drive_m(1'b1, 1'b1, 1'b0, 4'd9, 4'hF, 128'h9999, 128'd0);
    bus.flush_W = 1'b1;
    tick();
    bus.flush_W = 1'b0;
    idle_m();
    bus.ready_W = 1'b1;
    check("flush_valid", 128'(bus.valid_W), 128'd0);
    check("flush_ready", 128'(bus.ready_M), 128'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_nothing", 128'(bus.valid_W), 128'd0);
    end
    // Flush while empty and ready: the M entry is dropped
    drive_m(1'b1, 1'b1, 1'b0, 4'd8, 4'hF, 128'h8888, 128'd0);
    bus.flush_W = 1'b1;
    tick();
    bus.flush_W = 1'b0;
    idle_m();
    check("flush_drop_m", 128'(bus.valid_W), 128'd0);
    tick();
    check("flush_drop_m2", 128'(bus.valid_W), 128'd0);

    // Zero lane mask suppresses regw
    drive_m(1'b1, 1'b1, 1'b0, 4'd6, 4'h0, 128'h1234, 128'd0);
    tick();
    idle_m();
    check("zmask_valid", 128'(bus.valid_W), 128'd1);
    check("zmask_regw", 128'(bus.regw_W), 128'd0);
    check("zmask_data", bus.wbdata_W, 128'h1234);
`ifdef MWPIPE_FWD_EN
    check("zmask_fwd", 128'(fwd_valid), 128'd0);
`endif
    // Partial mask keeps regw
    drive_m(1'b1, 1'b1, 1'b0, 4'd10, 4'h2, 128'h5678, 128'd0);
    tick();
    idle_m();
    check("pmask_regw", 128'(bus.regw_W), 128'd1);
    check("pmask_mask", 128'(bus.lanemask_W), 128'(4'h2));
`ifdef MWPIPE_FWD_EN
    check("pmask_fwd_v", 128'(fwd_valid), 128'd1);
    check("pmask_fwd_r", 128'(fwd_reg), 128'd10);
    check("pmask_fwd_d", fwd_data, 128'h5678);
`endif
    tick();

    // Reset mid-stall discards held entries
    bus.ready_W = 1'b0;
    drive_m(1'b1, 1'b1, 1'b0, 4'd11, 4'hF, 128'hB0B0, 128'd0);
    tick();
    drive_m(1'b1, 1'b1, 1'b0, 4'd12, 4'hF, 128'hC0C0, 128'd0);
    tick();
    idle_m();
    rst = 1'b0;
    tick();
    check("mrst_valid", 128'(bus.valid_W), 128'd0);
    check("mrst_ready", 128'(bus.ready_M), 128'd0);
    check("mrst_scr", 128'(bus.regScr_W), 128'd0);
    check("mrst_data", bus.wbdata_W, 128'd0);
    rst = 1'b1;
    bus.ready_W = 1'b1;
    tick();
    check("mrst_rel_ready", 128'(bus.ready_M), 128'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mrst_nothing", 128'(bus.valid_W), 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
